// File: rtl/rns_pkg.sv
// Shared constants, types and helpers for the RNS FIR datapath.
// Default channel set: four 8-bit residues with moduli 233, 239, 241 and 251.
// MODULI[i*RES_W +: RES_W] is the modulus of channel i.
package rns_pkg;

  localparam int NUM_MOD = 4;
  localparam int RES_W   = 8;
  localparam logic [NUM_MOD*RES_W-1:0] MODULI = {8'd251, 8'd241, 8'd239, 8'd233};

  typedef logic [RES_W-1:0]        residue_t;
  typedef residue_t [NUM_MOD-1:0]  rns_vec_t;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  // Reduce a value by a modulus; m is always an elaboration-time constant
  // at the call sites, so this folds into constant-modulus reduction logic.
  function automatic logic [31:0] mod_reduce(input logic [31:0] v, input logic [31:0] m);
    return v % m;
  endfunction

endpackage

// File: rtl/rns_mod_mac.sv
// One residue channel: modular multiply-accumulate register for a fixed modulus.
// acc_nxt is the value the accumulator takes on the next enabled edge, exposed
// so the sequencer can capture the final sum on the last tap without an extra cycle.
module rns_mod_mac #(
  parameter int          RES_W = rns_pkg::RES_W,
  parameter int unsigned MOD   = 251
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [RES_W-1:0] c,
  input  logic [RES_W-1:0] d,
  output logic [RES_W-1:0] acc_nxt
);
  import rns_pkg::*;

  logic [RES_W-1:0]   acc;
  logic [2*RES_W-1:0] prod;
  logic [RES_W-1:0]   prod_red;
  logic [RES_W:0]     sum;

  // Product reduced by the constant modulus, then a single conditional
  // subtract since both addends are already below MOD.
  always_comb begin
    prod     = {{RES_W{1'b0}}, c} * {{RES_W{1'b0}}, d};
    prod_red = RES_W'(mod_reduce(32'(prod), 32'(MOD)));
    sum      = {1'b0, acc} + {1'b0, prod_red};
    if (sum >= (RES_W+1)'(MOD)) acc_nxt = RES_W'(sum - (RES_W+1)'(MOD));
    else                        acc_nxt = sum[RES_W-1:0];
  end

  // Accumulator register: cleared on sample accept, advanced on each MAC cycle.
  always_ff @(posedge clk) begin
    if (reset)    acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc_nxt;
  end

endmodule

// File: rtl/rns_fir_seq.sv
// Time-multiplexed RNS FIR: one modular MAC per residue channel, iterated over
// TAPS cycles per sample, with run-time loadable coefficients.
// Optional build macro RNS_FIR_RANGE_CHK_EN adds the sticky err port and
// reduction of out-of-range input residues on accept.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted here only
// MAC   | one tap per cycle, k = 0 .. TAPS-1
// OUT   | result held on y until the consumer takes it
module rns_fir_seq #(
  parameter int NUM_MOD = rns_pkg::NUM_MOD,
  parameter int RES_W   = rns_pkg::RES_W,
  parameter int TAPS    = 8,
  parameter logic [NUM_MOD*RES_W-1:0] MODULI = rns_pkg::MODULI,
  localparam int ADDR_W = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_MOD*RES_W-1:0] x,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_MOD*RES_W-1:0] y,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic [NUM_MOD*RES_W-1:0] coef_data,
  output logic                     coef_busy
`ifdef RNS_FIR_RANGE_CHK_EN
  ,
  output logic [NUM_MOD-1:0]       err
`endif
);
  import rns_pkg::*;

  localparam int VW = NUM_MOD*RES_W;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k;
  logic [VW-1:0]     coef [TAPS];
  logic [VW-1:0]     dly  [TAPS];
  logic [VW-1:0]     x_in;
  logic [VW-1:0]     sum_all;
  logic              accept, last, coef_wr, mac_en;

  assign in_ready  = (state == IDLE) && !reset;
  assign coef_busy = (state != IDLE);
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;
  assign mac_en    = (state == MAC);
  assign last      = (32'(k) == 32'(TAPS - 1));
  assign coef_wr   = coef_we && !coef_busy && (32'(coef_addr) < 32'(TAPS));

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = MAC;
      MAC:     if (last)      state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Tap index: restarts on accept, steps once per MAC cycle.
  always_ff @(posedge clk) begin
    if (reset)       k <= '0;
    else if (accept) k <= '0;
    else if (mac_en) k <= k + 1'b1;
  end

  // Coefficient store; a write on the accept edge lands before the first MAC read.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) coef[i] <= '0;
    end else if (coef_wr) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Delay line shifts only on accept; reset is the only flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) dly[i] <= '0;
    end else if (accept) begin
      dly[0] <= x_in;
      for (int i = 1; i < TAPS; i++) dly[i] <= dly[i-1];
    end
  end

  // Result register captures the final accumulator value on the last tap.
  always_ff @(posedge clk) begin
    if (reset)               y <= '0;
    else if (mac_en && last) y <= sum_all;
  end

`ifdef RNS_FIR_RANGE_CHK_EN
  logic [NUM_MOD-1:0] bad;

  // Range flags are sticky across samples until reset.
  always_ff @(posedge clk) begin
    if (reset)       err <= '0;
    else if (accept) err <= err | bad;
  end
`endif

  for (genvar i = 0; i < NUM_MOD; i++) begin : g_ch
    localparam int unsigned M = 32'(MODULI[i*RES_W +: RES_W]);

`ifdef RNS_FIR_RANGE_CHK_EN
    logic [RES_W-1:0] raw;
    assign raw    = x[i*RES_W +: RES_W];
    assign bad[i] = (32'(raw) >= 32'(M));
    // Out-of-range residues are folded once if below 2m, otherwise zeroed.
    assign x_in[i*RES_W +: RES_W] = !bad[i]                  ? raw :
                                    (32'(raw) < 32'(2 * M))  ? RES_W'(32'(raw) - 32'(M)) :
                                                               '0;
`else
    assign x_in[i*RES_W +: RES_W] = x[i*RES_W +: RES_W];
`endif

    rns_mod_mac #(
      .RES_W (RES_W),
      .MOD   (M)
    ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .clr     (accept),
      .en      (mac_en),
      .c       (coef[k][i*RES_W +: RES_W]),
      .d       (dly[k][i*RES_W +: RES_W]),
      .acc_nxt (sum_all[i*RES_W +: RES_W])
    );
  end

endmodule
